// File: rtl/dmem_arbiter.sv
// Two-port (core/DMA) arbiter in front of a single-port data memory; one access per 2 cycles.
// Tie-break: fixed priority to port 0, or round-robin when DMEM_ARB_ROUND_ROBIN_EN is defined.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_write_en,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } acc_t;

  state_t state, state_nxt;
  acc_t   cap;
  logic   last_winner;
  logic   win;
  logic   busy;

  // Winning port index; only meaningful when at least one req is high
  always_comb begin
    win = req1;
    if (req0 && req1)
      win = RR_EN ? ~last_winner : 1'b0;
  end

  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    case (state)
      IDLE: begin
        if (reset && (req0 || req1)) begin
          gnt0      = ~win;
          gnt1      = win;
          state_nxt = win ? BUSY1 : BUSY0;
        end
      end
      BUSY0, BUSY1: state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cap         <= '0;
      last_winner <= 1'b1;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      state   <= state_nxt;
      rvalid0 <= (state == BUSY0);
      rvalid1 <= (state == BUSY1);
      if (gnt0 || gnt1) begin
        cap         <= gnt1 ? acc_t'{we1, addr1, wdata1} : acc_t'{we0, addr0, wdata0};
        last_winner <= gnt1;
      end
      if (state == BUSY0 && !cap.we) rdata0 <= mem_read_data;
      if (state == BUSY1 && !cap.we) rdata1 <= mem_read_data;
    end
  end

  assign busy           = (state == BUSY0) || (state == BUSY1);
  assign mem_addr       = cap.addr;
  assign mem_write_data = cap.wdata;
  // Strobe is gated by reset so it drops asynchronously, not just on the next edge
  assign mem_write_en   = reset && busy && cap.we;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed literal checks plus randomized traffic against a transaction-level model.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0, mem_read_data = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_write_en;
  logic [DW-1:0] rdata0, rdata1, mem_write_data;
  logic [AW-1:0] mem_addr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_write_en(mem_write_en),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: a granted access occupies the memory for the next cycle,
  // and completes (rvalid) in the cycle after that.
  bit            m_inflight, m_we, m_done;
  int            m_port, m_done_port, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata [2];

  function automatic int pick(input bit r0, input bit r1);
    if (r0 && r1) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      return (m_last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    return r1 ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    int w;
    bit g;
    if (!reset) begin
      m_inflight = 0; m_done = 0; m_we = 0; m_port = 0; m_done_port = 0;
      m_addr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0; m_last = 1;
    end
    g = reset && !m_inflight && (req0 || req1);
    w = pick(req0, req1);
    chk("gnt", 64'({gnt1, gnt0}), 64'(g ? (w == 1 ? 2'b10 : 2'b01) : 2'b00));
    chk("rvalid", 64'({rvalid1, rvalid0}), 64'(m_done ? (m_done_port == 1 ? 2'b10 : 2'b01) : 2'b00));
    chk("rdata0", 64'(rdata0), 64'(m_rdata[0]));
    chk("rdata1", 64'(rdata1), 64'(m_rdata[1]));
    chk("mem_write_en", 64'(mem_write_en), 64'(m_inflight && m_we));
    chk("mem_addr", 64'(mem_addr), 64'(m_addr));
    chk("mem_write_data", 64'(mem_write_data), 64'(m_wdata));
    if (reset) begin
      m_done      = m_inflight;
      m_done_port = m_port;
      if (m_inflight && !m_we) m_rdata[m_port] = mem_read_data;
      m_inflight = g;
      if (g) begin
        m_port  = w;
        m_last  = w;
        m_we    = (w == 1) ? we1 : we0;
        m_addr  = (w == 1) ? addr1 : addr0;
        m_wdata = (w == 1) ? wdata1 : wdata0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
  endtask

  logic [1:0] tie_exp [4];

  initial begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b10; tie_exp[2] = 2'b01; tie_exp[3] = 2'b10;
`else
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b01; tie_exp[2] = 2'b01; tie_exp[3] = 2'b01;
`endif

    // Reset with requests pending: no grant may leak out
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_gnt", 64'({gnt1, gnt0}), 64'd0);
    chk("rst_we", 64'(mem_write_en), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    tick();
    idle_in();
    reset = 1'b1;
    repeat (2) tick();

    // Single read on port 0
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    @(negedge clk); chk("rd_gnt0", 64'(gnt0), 64'd1);
    tick(); req0 = 1'b0; mem_read_data = 32'hDEADBEEF;
    @(negedge clk); chk("rd_addr", 64'(mem_addr), 64'h10); chk("rd_we", 64'(mem_write_en), 64'd0);
    tick(); mem_read_data = '0;
    @(negedge clk); chk("rd_rvalid0", 64'(rvalid0), 64'd1); chk("rd_rdata0", 64'(rdata0), 64'hDEADBEEF);
    tick();

    // Single write on port 1
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h12345678;
    @(negedge clk); chk("wr_gnt1", 64'(gnt1), 64'd1); chk("wr_we_early", 64'(mem_write_en), 64'd0);
    tick(); idle_in();
    @(negedge clk);
    chk("wr_we", 64'(mem_write_en), 64'd1);
    chk("wr_addr", 64'(mem_addr), 64'h20);
    chk("wr_data", 64'(mem_write_data), 64'h12345678);
    tick();
    @(negedge clk); chk("wr_rvalid1", 64'(rvalid1), 64'd1); chk("wr_we_late", 64'(mem_write_en), 64'd0);
    tick();

    // Tie held for 8 cycles; last grant before this was port 1
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k % 2 == 0) chk("tie_gnt", 64'({gnt1, gnt0}), 64'(tie_exp[k / 2]));
      tick();
    end

    // Reset during the busy cycle of a port-1 write
    idle_in();
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h44; wdata1 = 32'hA5A5;
    @(negedge clk); chk("abort_gnt1", 64'(gnt1), 64'd1);
    tick(); idle_in();
    @(negedge clk); chk("abort_we_pre", 64'(mem_write_en), 64'd1);
    #1 reset = 1'b0;
    #1 chk("abort_we", 64'(mem_write_en), 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("abort_rvalid1", 64'(rvalid1), 64'd0);
      tick();
    end

    // Back-to-back reads on port 0
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h80;
    for (int k = 0; k < 6; k++) begin
      mem_read_data = $urandom;
      @(negedge clk);
      chk("b2b_gnt0", 64'(gnt0), 64'(k % 2 == 0));
      chk("b2b_rvalid0", 64'(rvalid0), 64'(k >= 2 && k % 2 == 0));
      tick();
    end
    idle_in();

    // Random traffic with occasional resets
    for (int k = 0; k < 800; k++) begin
      req0 = ($urandom_range(0, 9) < 6); req1 = ($urandom_range(0, 9) < 6);
      we0 = $urandom_range(0, 1); we1 = $urandom_range(0, 1);
      addr0 = $urandom; addr1 = $urandom; wdata0 = $urandom; wdata1 = $urandom;
      mem_read_data = $urandom;
      if (reset && $urandom_range(0, 59) == 0) reset = 1'b0;
      else if (!reset && $urandom_range(0, 1) == 1) reset = 1'b1;
      @(negedge clk);
      tick();
    end
    idle_in();
    reset = 1'b1;
    repeat (3) tick();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
